// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline stage register.
//
// Carries an opaque payload (i_Data), a control vector (i_Ctrl) and a sticky
// selector (i_Hold) from an upstream valid/ready interface to a downstream one.
// The control vector is zero whenever the output slot is empty. The selector
// keeps its value when the slot empties. On a flush it either keeps its value
// or returns to HOLD_RST.
//
// Build option: define PIPE_STAGE_SKID_EN to add a one-entry skid register.
// With the skid, o_Ready depends only on a flop and on i_Bubble, so there is no
// combinational path from i_Ready to o_Ready, and the stage holds two items.
// Without the skid, o_Ready is combinational from i_Ready and the stage holds
// one item.
//
// Ports:
//   i_Clk, i_Rst_n          clock (rising edge), async active-low reset
//   i_Valid/o_Ready         upstream handshake; i_Data/i_Ctrl/i_Hold payload
//   o_Valid/i_Ready         downstream handshake; o_Data/o_Ctrl/o_Hold payload
//   i_Bubble                refuse upstream this cycle; the output drains
//   i_Flush, i_HoldKeep     drop all held items; optionally keep o_Hold
//   o_StallCnt              saturating count of cycles with o_Valid && !i_Ready
module pipe_stage_reg #(
  parameter int unsigned       DATA_W   = 128,
  parameter int unsigned       CTRL_W   = 24,
  parameter int unsigned       HOLD_W   = 2,
  parameter logic [HOLD_W-1:0] HOLD_RST = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Valid,
  output logic              o_Ready,
  input  logic [DATA_W-1:0] i_Data,
  input  logic [CTRL_W-1:0] i_Ctrl,
  input  logic [HOLD_W-1:0] i_Hold,
  output logic              o_Valid,
  input  logic              i_Ready,
  output logic [DATA_W-1:0] o_Data,
  output logic [CTRL_W-1:0] o_Ctrl,
  output logic [HOLD_W-1:0] o_Hold,
  input  logic              i_Bubble,
  input  logic              i_Flush,
  input  logic              i_HoldKeep,
  output logic [CNT_W-1:0]  o_StallCnt
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              up_xfer;
  logic              dn_xfer;

  assign up_xfer = i_Valid & o_Ready;
  assign dn_xfer = valid_q & i_Ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [HOLD_W-1:0] skid_hold_q, skid_hold_d;

  // Ready comes only from the skid occupancy flop. A full skid means the
  // stage already holds two items.
  assign o_Ready = ~i_Bubble & ~skid_valid_q;

  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    ctrl_d       = ctrl_q;
    hold_d       = hold_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_hold_d  = skid_hold_q;
    if (i_Flush) begin
      valid_d      = 1'b0;
      data_d       = '0;
      ctrl_d       = '0;
      hold_d       = i_HoldKeep ? hold_q : HOLD_RST;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
      skid_ctrl_d  = '0;
      skid_hold_d  = HOLD_RST;
    end else if (dn_xfer) begin
      if (skid_valid_q) begin
        // o_Ready is low while the skid is full, so there is no
        // upstream transfer to handle in this branch.
        data_d       = skid_data_q;
        ctrl_d       = skid_ctrl_q;
        hold_d       = skid_hold_q;
        skid_valid_d = 1'b0;
        skid_data_d  = '0;
        skid_ctrl_d  = '0;
      end else if (up_xfer) begin
        data_d = i_Data;
        ctrl_d = i_Ctrl;
        hold_d = i_Hold;
      end else begin
        valid_d = 1'b0;
        data_d  = '0;
        ctrl_d  = '0;
      end
    end else if (!valid_q) begin
      if (up_xfer) begin
        valid_d = 1'b1;
        data_d  = i_Data;
        ctrl_d  = i_Ctrl;
        hold_d  = i_Hold;
      end
    end else if (up_xfer) begin
      // Main slot is stalled, so the arriving item is parked in the skid.
      skid_valid_d = 1'b1;
      skid_data_d  = i_Data;
      skid_ctrl_d  = i_Ctrl;
      skid_hold_d  = i_Hold;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
      skid_hold_q  <= HOLD_RST;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_hold_q  <= skid_hold_d;
    end
  end
`else
  assign o_Ready = ~i_Bubble & (i_Ready | ~valid_q);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    hold_d  = hold_q;
    if (i_Flush) begin
      valid_d = 1'b0;
      data_d  = '0;
      ctrl_d  = '0;
      hold_d  = i_HoldKeep ? hold_q : HOLD_RST;
    end else if (up_xfer) begin
      // o_Ready guarantees the slot is empty or being consumed.
      valid_d = 1'b1;
      data_d  = i_Data;
      ctrl_d  = i_Ctrl;
      hold_d  = i_Hold;
    end else if (dn_xfer) begin
      valid_d = 1'b0;
      data_d  = '0;
      ctrl_d  = '0;
    end
  end
`endif

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_q && !i_Ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      valid_q     <= 1'b0;
      data_q      <= '0;
      ctrl_q      <= '0;
      hold_q      <= HOLD_RST;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      hold_q      <= hold_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_Valid    = valid_q;
  assign o_Data     = data_q;
  assign o_Ctrl     = ctrl_q;
  assign o_Hold     = hold_q;
  assign o_StallCnt = stall_cnt_q;

endmodule
